// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: host byte stream in, instruction-memory write port and loader status out.
interface inst_mem_loader_if #(
   parameter int ADDR_W = 14
);
   logic start, byte_valid, byte_ready, mem_we, cpu_hold, done, overflow, error;
   logic [7:0] byte_in;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0] mem_din;
   modport master (
      output start, byte_in, byte_valid,
      input byte_ready, mem_we, mem_addr, mem_din, cpu_hold, done, overflow, error
   );
   modport slave (
      input start, byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_din, cpu_hold, done, overflow, error
   );
endinterface

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: assembles big-endian words from a byte stream into instruction memory, holding the CPU while loading.
// Define LOADER_CHECKSUM_EN to expect a trailing 16-bit sum of the data words.
module inst_mem_loader #(
   parameter int ADDR_W = 14
) (
   input logic CLK,
   input logic Reset,
   inst_mem_loader_if.slave bus
);
   typedef enum logic [3:0] {IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE,
`ifdef LOADER_CHECKSUM_EN
      CK_HI, CK_LO,
`endif
      DONE} state_t;
`ifdef LOADER_CHECKSUM_EN
   localparam state_t TAIL = CK_HI;
`else
   localparam state_t TAIL = DONE;
`endif
   localparam logic [ADDR_W-1:0] LAST = '1;
   state_t state, nxt;
   logic [15:0] len, din;
   logic [ADDR_W-1:0] addr;
   logic full, ovf, err, ready, fire;
   assign ready = !(state inside {IDLE, WRITE, DONE});
   assign fire = bus.byte_valid && ready;
   assign bus.byte_ready = ready;
   assign bus.mem_we = state == WRITE && !full;
   assign bus.mem_addr = addr;
   assign bus.mem_din = din;
   assign bus.done = state == DONE;
   assign bus.cpu_hold = (state != IDLE && state != DONE) || err;
   assign bus.overflow = ovf;
   assign bus.error = err;
   always_comb begin
      nxt = state;
      case (state)
         IDLE: nxt = bus.start ? LEN_HI : IDLE;
         LEN_HI: nxt = fire ? LEN_LO : LEN_HI;
         LEN_LO: nxt = !fire ? LEN_LO : ({len[15:8], bus.byte_in} == 16'd0) ? TAIL : DAT_HI;
         DAT_HI: nxt = fire ? DAT_LO : DAT_HI;
         DAT_LO: nxt = fire ? WRITE : DAT_LO;
         WRITE: nxt = (len == 16'd1) ? TAIL : DAT_HI;
`ifdef LOADER_CHECKSUM_EN
         CK_HI: nxt = fire ? CK_LO : CK_HI;
         CK_LO: nxt = fire ? DONE : CK_LO;
`endif
         default: nxt = IDLE;
      endcase
   end
`ifdef LOADER_CHECKSUM_EN
   logic [15:0] sum;
`else
   assign err = 1'b0;
`endif
   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= IDLE;
         len <= '0;
         din <= '0;
         addr <= '0;
         full <= 1'b0;
         ovf <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum <= '0;
         err <= 1'b0;
`endif
      end else begin
         state <= nxt;
         if (state == IDLE && bus.start) begin
            addr <= '0;
            full <= 1'b0;
            ovf <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum <= '0;
            err <= 1'b0;
`endif
         end
         if (fire && state == LEN_HI) len[15:8] <= bus.byte_in;
         if (fire && state == LEN_LO) len[7:0] <= bus.byte_in;
         if (fire && state == DAT_HI) din[15:8] <= bus.byte_in;
         if (fire && state == DAT_LO) din[7:0] <= bus.byte_in;
         // full marks that the last address has been written; later words only flag overflow
         if (state == WRITE) begin
            len <= len - 16'd1;
            ovf <= ovf | full;
            full <= full | (addr == LAST);
            if (!full && addr != LAST) addr <= addr + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + din;
`endif
         end
`ifdef LOADER_CHECKSUM_EN
         // the high data byte register is free after the last write and holds the checksum high byte
         if (fire && state == CK_HI) din[15:8] <= bus.byte_in;
         if (fire && state == CK_LO) err <= {din[15:8], bus.byte_in} != sum;
`endif
      end
   end
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: directed tests of the loader with a full-size and a 4-word instance fed the same stream.
module tb_inst_mem_loader;
   logic CLK = 1'b0;
   logic Reset = 1'b1;
   logic start = 1'b0;
   logic byte_valid = 1'b0;
   logic [7:0] byte_in = 8'h00;
   always #5 CLK = ~CLK;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif
   inst_mem_loader_if #(.ADDR_W(14)) a();
   inst_mem_loader_if #(.ADDR_W(2)) b();
   assign a.start = start;
   assign a.byte_valid = byte_valid;
   assign a.byte_in = byte_in;
   assign b.start = start;
   assign b.byte_valid = byte_valid;
   assign b.byte_in = byte_in;
   inst_mem_loader #(.ADDR_W(14)) dut_a (.CLK(CLK), .Reset(Reset), .bus(a));
   inst_mem_loader #(.ADDR_W(2)) dut_b (.CLK(CLK), .Reset(Reset), .bus(b));
   int errors = 0, checks = 0, cyc = 0;
   int na = 0, nb = 0, nd = 0, nx = 0, nh = 0, done_cyc = 0;
   int na0, nb0, nd0, nx0, nh0;
   logic [13:0] wa_addr [64];
   logic [15:0] wa_din [64];
   logic [1:0] wb_addr [64];
   logic [15:0] wb_din [64];
   int we_cyc [64];
   int xc [64];
   logic [15:0] wds [8];
   always @(posedge CLK) cyc <= cyc + 1;
   always @(negedge CLK) begin
      if (a.mem_we && na < 64) begin
         wa_addr[na] = a.mem_addr;
         wa_din[na] = a.mem_din;
         we_cyc[na] = cyc;
         na++;
      end
      if (b.mem_we && nb < 64) begin
         wb_addr[nb] = b.mem_addr;
         wb_din[nb] = b.mem_din;
         nb++;
      end
      if (a.done) begin
         nd++;
         done_cyc = cyc;
      end
      if (a.byte_valid && a.byte_ready && nx < 64) begin
         xc[nx] = cyc;
         nx++;
      end
      if (a.cpu_hold) nh++;
   end
   task automatic do_start();
      @(posedge CLK);
      #1 start = 1'b1;
      @(posedge CLK);
      #1 start = 1'b0;
      checks++;
      if ({a.cpu_hold, a.byte_ready} !== 2'b11) begin
         errors++;
         $display("FAIL start_hold got hold,ready=%b required 11", {a.cpu_hold, a.byte_ready});
      end
   endtask
   task automatic send(input logic [7:0] v, input bit gap);
      bit ok;
      ok = 1'b0;
      byte_in = v;
      byte_valid = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge CLK);
         ok = a.byte_ready;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL send_timeout byte=%h got ready=0 required 1", v);
      end
      @(posedge CLK);
      #1;
      if (gap) begin
         byte_valid = 1'b0;
         @(posedge CLK);
         #1;
      end
   endtask
   task automatic run_load(input int n, input bit gap, input bit bad);
      logic [15:0] s, nn;
      bit ok;
      s = 16'(bad);
      nn = n[15:0];
      na0 = na; nb0 = nb; nd0 = nd; nx0 = nx; nh0 = nh;
      do_start();
      send(nn[15:8], gap);
      send(nn[7:0], gap);
      for (int i = 0; i < n; i++) begin
         send(wds[i][15:8], gap);
         send(wds[i][7:0], gap);
         s = s + wds[i];
      end
`ifdef LOADER_CHECKSUM_EN
      send(s[15:8], gap);
      send(s[7:0], gap);
`endif
      byte_valid = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge CLK);
         ok = nd > nd0;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL done_timeout got no done required a pulse");
      end
      repeat (3) @(negedge CLK);
   endtask
   task automatic test_reset();
      repeat (3) @(posedge CLK);
      #1 Reset = 1'b0;
      @(negedge CLK);
      checks++;
      if ({a.byte_ready, a.mem_we, a.mem_addr, a.mem_din, a.cpu_hold, a.done, a.overflow, a.error} !== 36'd0) begin
         errors++;
         $display("FAIL reset_a got %h required 0", {a.byte_ready, a.mem_we, a.mem_addr, a.mem_din, a.cpu_hold, a.done, a.overflow, a.error});
      end
      checks++;
      if ({b.byte_ready, b.mem_we, b.mem_addr, b.mem_din, b.cpu_hold, b.done, b.overflow, b.error} !== 24'd0) begin
         errors++;
         $display("FAIL reset_b got %h required 0", {b.byte_ready, b.mem_we, b.mem_addr, b.mem_din, b.cpu_hold, b.done, b.overflow, b.error});
      end
   endtask
   task automatic test_basic();
      wds[0] = 16'h1234;
      wds[1] = 16'hABCD;
      run_load(2, 1'b0, 1'b0);
      checks++;
      if (na - na0 != 2) begin errors++; $display("FAIL basic_writes got %0d required 2", na - na0); end
      checks++;
      if ({wa_addr[na0], wa_din[na0]} !== {14'd0, 16'h1234}) begin
         errors++; $display("FAIL basic_w0 got %h@%h required 1234@0", wa_din[na0], wa_addr[na0]);
      end
      checks++;
      if ({wa_addr[na0+1], wa_din[na0+1]} !== {14'd1, 16'hABCD}) begin
         errors++; $display("FAIL basic_w1 got %h@%h required abcd@1", wa_din[na0+1], wa_addr[na0+1]);
      end
      checks++;
      if (nd - nd0 != 1) begin errors++; $display("FAIL basic_done got %0d pulses required 1", nd - nd0); end
      checks++;
      if (nh == nh0 || a.cpu_hold !== 1'b0) begin
         errors++; $display("FAIL basic_hold got %0d hold cycles, final %b required >0 and 0", nh - nh0, a.cpu_hold);
      end
      checks++;
      if (we_cyc[na0] - xc[nx0+3] != 1) begin
         errors++; $display("FAIL basic_write_lat got %0d required 1", we_cyc[na0] - xc[nx0+3]);
      end
      checks++;
      if (done_cyc - xc[nx-1] != (CK ? 1 : 2)) begin
         errors++; $display("FAIL basic_done_lat got %0d required %0d", done_cyc - xc[nx-1], CK ? 1 : 2);
      end
      checks++;
      if (nb - nb0 != 2) begin errors++; $display("FAIL basic_writes_b got %0d required 2", nb - nb0); end
   endtask
   task automatic test_stall();
      wds[0] = 16'h1234;
      wds[1] = 16'hABCD;
      run_load(2, 1'b1, 1'b0);
      checks++;
      if (nx - nx0 != (CK ? 8 : 6)) begin errors++; $display("FAIL stall_bytes got %0d required %0d", nx - nx0, CK ? 8 : 6); end
      checks++;
      if (na - na0 != 2 || {wa_addr[na0], wa_din[na0], wa_addr[na0+1], wa_din[na0+1]} !== {14'd0, 16'h1234, 14'd1, 16'hABCD}) begin
         errors++; $display("FAIL stall_writes got %0d writes %h@%h %h@%h required 1234@0 abcd@1",
                             na - na0, wa_din[na0], wa_addr[na0], wa_din[na0+1], wa_addr[na0+1]);
      end
      checks++;
      if (nd - nd0 != 1) begin errors++; $display("FAIL stall_done got %0d required 1", nd - nd0); end
   endtask
   task automatic test_zero();
      run_load(0, 1'b0, 1'b0);
      checks++;
      if (na - na0 != 0) begin errors++; $display("FAIL zero_writes got %0d required 0", na - na0); end
      checks++;
      if (nd - nd0 != 1) begin errors++; $display("FAIL zero_done got %0d required 1", nd - nd0); end
      checks++;
      if (done_cyc - xc[nx-1] != 1) begin errors++; $display("FAIL zero_done_lat got %0d required 1", done_cyc - xc[nx-1]); end
   endtask
   task automatic test_overflow();
      for (int i = 0; i < 5; i++) wds[i] = 16'h1111 * 16'(i + 1);
      run_load(5, 1'b0, 1'b0);
      checks++;
      if (nb - nb0 != 4) begin errors++; $display("FAIL ovf_writes got %0d required 4", nb - nb0); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({wb_addr[nb0+i], wb_din[nb0+i]} !== {2'(i), wds[i]}) begin
            errors++; $display("FAIL ovf_w%0d got %h@%h required %h@%0d", i, wb_din[nb0+i], wb_addr[nb0+i], wds[i], i);
         end
      end
      checks++;
      if ({b.overflow, b.mem_addr} !== 3'b111) begin errors++; $display("FAIL ovf_flag got ovf,addr=%b required 111", {b.overflow, b.mem_addr}); end
      checks++;
      if (a.overflow !== 1'b0 || na - na0 != 5) begin errors++; $display("FAIL ovf_big got ovf=%b writes=%0d required 0,5", a.overflow, na - na0); end
      checks++;
      if (nd - nd0 != 1) begin errors++; $display("FAIL ovf_done got %0d required 1", nd - nd0); end
   endtask
   task automatic test_reset_mid();
      nd0 = nd;
      do_start();
      checks++;
      if (b.overflow !== 1'b0) begin errors++; $display("FAIL mid_ovf_clear got %b required 0", b.overflow); end
      send(8'h00, 1'b0);
      send(8'h01, 1'b0);
      send(8'h12, 1'b0);
      Reset = 1'b1;
      byte_valid = 1'b0;
      @(posedge CLK);
      #1 Reset = 1'b0;
      checks++;
      if ({a.cpu_hold, a.byte_ready, a.mem_we} !== 3'b000) begin
         errors++; $display("FAIL mid_idle got hold,ready,we=%b required 000", {a.cpu_hold, a.byte_ready, a.mem_we});
      end
      repeat (3) @(negedge CLK);
      checks++;
      if (nd != nd0) begin errors++; $display("FAIL mid_no_done got %0d pulses required 0", nd - nd0); end
      test_basic();
   endtask
`ifdef LOADER_CHECKSUM_EN
   task automatic test_checksum();
      wds[0] = 16'h0005;
      run_load(1, 1'b0, 1'b0);
      checks++;
      if ({a.error, a.cpu_hold} !== 2'b00 || nd - nd0 != 1) begin
         errors++; $display("FAIL ck_good got err,hold=%b done=%0d required 00 1", {a.error, a.cpu_hold}, nd - nd0);
      end
      run_load(1, 1'b0, 1'b1);
      checks++;
      if ({a.error, a.cpu_hold} !== 2'b11 || nd - nd0 != 1) begin
         errors++; $display("FAIL ck_bad got err,hold=%b done=%0d required 11 1", {a.error, a.cpu_hold}, nd - nd0);
      end
      @(posedge CLK);
      #1 Reset = 1'b1;
      @(posedge CLK);
      #1 Reset = 1'b0;
      checks++;
      if ({a.error, a.cpu_hold} !== 2'b00) begin errors++; $display("FAIL ck_reset got err,hold=%b required 00", {a.error, a.cpu_hold}); end
   endtask
`endif
   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero();
      test_overflow();
      test_reset_mid();
`ifdef LOADER_CHECKSUM_EN
      test_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
